// File: rtl/actuator_pkg.sv
// Shared types and sizing helpers for the actuator pulse driver.
package actuator_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam int unsigned CLK_HZ             = 125000000;
    localparam int unsigned DEFAULT_ON_CYCLES  = CLK_HZ / 10;  // 100 ms
    localparam int unsigned DEFAULT_OFF_CYCLES = CLK_HZ / 20;  // 50 ms

    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/actuator_pulse_driver.sv
// Turns single-cycle requests into timed drive pulses, each followed by a guard interval.
// Build option: ACT_QUEUE_EN enables queueing of requests that arrive while busy.
module actuator_pulse_driver
    import actuator_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = DEFAULT_ON_CYCLES,
    parameter int unsigned OFF_CYCLES  = DEFAULT_OFF_CYCLES,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req,
    input  logic                             abort,
    input  logic                             clr_overflow,
    output logic                             act_out,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending,
    output logic                             overflow
);

    localparam int unsigned     TW       = $clog2(max(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [TW-1:0]   ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]   OFF_LOAD = TW'(OFF_CYCLES - 1);

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic            act_n, done_n, ovf_n;
    logic            ovf_set, enq, expired, next_queued;

`ifdef ACT_QUEUE_EN
    localparam int unsigned   PW       = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(QUEUE_DEPTH);

    logic [PW-1:0] pend_q, pend_n;
    logic          last_cool;
`endif

    always_comb begin
        enq         = req & ~abort;
        expired     = (timer == '0);
        ovf_set     = 1'b0;
        next_queued = 1'b0;

`ifdef ACT_QUEUE_EN
        // Enqueue is resolved before dequeue so a request on the last guard
        // cycle with an empty queue passes straight through.
        pend_n    = pend_q;
        last_cool = (state == COOLDOWN) && expired;
        if (state != IDLE) begin
            if (abort) begin
                pend_n = '0;
            end else begin
                if (enq) begin
                    if (pend_q == PEND_MAX) ovf_set = 1'b1;
                    else                    pend_n  = pend_q + 1'b1;
                end
                if (last_cool && (pend_n != '0)) begin
                    next_queued = 1'b1;
                    pend_n      = pend_n - 1'b1;
                end
            end
        end
`else
        if ((state != IDLE) && enq) ovf_set = 1'b1;
`endif

        state_n = state;
        timer_n = timer;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (enq) begin
                    state_n = ACTIVE;
                    timer_n = ON_LOAD;
                end
            end
            ACTIVE: begin
                if (abort) begin
                    state_n = COOLDOWN;
                    timer_n = OFF_LOAD;
                end else if (expired) begin
                    state_n = COOLDOWN;
                    timer_n = OFF_LOAD;
                    done_n  = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            COOLDOWN: begin
                if (expired) begin
                    if (next_queued) begin
                        state_n = ACTIVE;
                        timer_n = ON_LOAD;
                    end else begin
                        state_n = IDLE;
                        timer_n = '0;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        act_n = (state_n == ACTIVE);
        ovf_n = ovf_set | (overflow & ~clr_overflow);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            act_out  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            act_out  <= act_n;
            done     <= done_n;
            overflow <= ovf_n;
        end
    end

`ifdef ACT_QUEUE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_n;
    end

    assign pending = pend_q;
`else
    assign pending = '0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_actuator_pulse_driver.sv
// Self-checking bench for actuator_pulse_driver (ON=4, OFF=3, QUEUE_DEPTH=2).
module tb_actuator_pulse_driver;

    localparam int ON    = 4;
    localparam int OFF   = 3;
    localparam int DEPTH = 2;
`ifdef ACT_QUEUE_EN
    localparam int QD = DEPTH;
`else
    localparam int QD = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, req, abort, clr_overflow;
    logic       act_out, busy, done, overflow;
    logic [1:0] pending;

    always #5 clk = ~clk;

    actuator_pulse_driver #(
        .ON_CYCLES   (ON),
        .OFF_CYCLES  (OFF),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .abort        (abort),
        .clr_overflow (clr_overflow),
        .act_out      (act_out),
        .busy         (busy),
        .done         (done),
        .pending      (pending),
        .overflow     (overflow)
    );

    int errors = 0;
    int checks = 0;
    int t;
    bit use_model;
    int s_act, s_busy, s_done, s_pend, s_ovf;

    // Reference: each accepted request owns a block [start, start+ON+OFF-1].
    int starts[$];
    bit m_ovf;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0d exp=%0d", name, t, got, exp);
        end
    endtask

    function automatic int m_busy(input int tt);
        foreach (starts[i]) if (tt >= starts[i] && tt <= starts[i] + ON + OFF - 1) return 1;
        return 0;
    endfunction

    function automatic int m_act(input int tt);
        foreach (starts[i]) if (tt >= starts[i] && tt < starts[i] + ON) return 1;
        return 0;
    endfunction

    function automatic int m_done(input int tt);
        foreach (starts[i]) if (tt == starts[i] + ON) return 1;
        return 0;
    endfunction

    function automatic int m_pend(input int tt);
        int n = 0;
        foreach (starts[i]) if (starts[i] > tt) n++;
        return n;
    endfunction

    task automatic model_step(input bit r, input bit c);
        bit drop = 1'b0;
        if (r) begin
            if (m_busy(t) == 0)        starts.push_back(t + 1);
            else if (m_pend(t) < QD)   starts.push_back(starts[$] + ON + OFF);
            else                       drop = 1'b1;
        end
        m_ovf = drop | (m_ovf & ~c);
    endtask

    task automatic tick(input bit r, input bit a, input bit c);
        req = r; abort = a; clr_overflow = c;
        @(negedge clk);
        s_act  = int'(act_out);
        s_busy = int'(busy);
        s_done = int'(done);
        s_pend = int'(pending);
        s_ovf  = int'(overflow);
        if (use_model) begin
            chk("rnd_act",  s_act,  m_act(t));
            chk("rnd_busy", s_busy, m_busy(t));
            chk("rnd_done", s_done, m_done(t));
            chk("rnd_pend", s_pend, m_pend(t));
            chk("rnd_ovf",  s_ovf,  int'(m_ovf));
        end
        model_step(r & ~a, c);
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        req = 1'b0; abort = 1'b0; clr_overflow = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        t = 0;
        starts.delete();
        m_ovf = 1'b0;
    endtask

    function automatic int q_act(input int c);
`ifdef ACT_QUEUE_EN
        return int'((c >= 1 && c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18));
`else
        return int'(c >= 1 && c <= 4);
`endif
    endfunction

    function automatic int q_pend(input int c);
`ifdef ACT_QUEUE_EN
        if (c < 3)   return 0;
        if (c == 3)  return 1;
        if (c <= 7)  return 2;
        if (c <= 14) return 1;
        return 0;
`else
        return 0;
`endif
    endfunction

    function automatic int q_ovf(input int c);
`ifdef ACT_QUEUE_EN
        return int'(c >= 5);
`else
        return int'(c >= 3);
`endif
    endfunction

    function automatic int lc_act(input int c);
`ifdef ACT_QUEUE_EN
        return int'((c >= 1 && c <= 4) || (c >= 8 && c <= 11));
`else
        return int'(c >= 1 && c <= 4);
`endif
    endfunction

    function automatic int lc_ovf(input int c);
`ifdef ACT_QUEUE_EN
        return 0;
`else
        return int'(c >= 8);
`endif
    endfunction

    typedef struct {
        bit r, a, c;
        bit act, bsy, dn;
        int pend;
        bit ovf;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #500000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1);
    end

    initial begin
        int k;
        use_model = 1'b0;
        t = 0;
        req = 1'b0; abort = 1'b0; clr_overflow = 1'b0;
        reset = 1'b1;
        #12;
        chk("rst_act",  int'(act_out),  0);
        chk("rst_busy", int'(busy),     0);
        chk("rst_done", int'(done),     0);
        chk("rst_pend", int'(pending),  0);
        chk("rst_ovf",  int'(overflow), 0);
        do_reset();

        // Single drive, then a drive aborted mid-pulse with a simultaneous req.
        tbl[0]  = '{1,0,0, 0,0,0, 0,0};
        tbl[1]  = '{0,0,0, 1,1,0, 0,0};
        tbl[2]  = '{0,0,0, 1,1,0, 0,0};
        tbl[3]  = '{0,0,0, 1,1,0, 0,0};
        tbl[4]  = '{0,0,0, 1,1,0, 0,0};
        tbl[5]  = '{0,0,0, 0,1,1, 0,0};
        tbl[6]  = '{0,0,0, 0,1,0, 0,0};
        tbl[7]  = '{0,0,0, 0,1,0, 0,0};
        tbl[8]  = '{0,0,0, 0,0,0, 0,0};
        tbl[9]  = '{1,0,0, 0,0,0, 0,0};
        tbl[10] = '{0,0,0, 1,1,0, 0,0};
        tbl[11] = '{1,1,0, 1,1,0, 0,0};
        tbl[12] = '{0,0,0, 0,1,0, 0,0};
        tbl[13] = '{0,0,0, 0,1,0, 0,0};
        tbl[14] = '{0,0,0, 0,1,0, 0,0};
        tbl[15] = '{0,0,0, 0,0,0, 0,0};
        tbl[16] = '{0,0,0, 0,0,0, 0,0};
        for (int i = 0; i < 17; i++) begin
            tick(tbl[i].r, tbl[i].a, tbl[i].c);
            chk($sformatf("tbl%0d_act",  i), s_act,  int'(tbl[i].act));
            chk($sformatf("tbl%0d_busy", i), s_busy, int'(tbl[i].bsy));
            chk($sformatf("tbl%0d_done", i), s_done, int'(tbl[i].dn));
            chk($sformatf("tbl%0d_pend", i), s_pend, tbl[i].pend);
            chk($sformatf("tbl%0d_ovf",  i), s_ovf,  int'(tbl[i].ovf));
        end

        // Requests at 0,2,3,4: queue fills, fourth is dropped.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            tick(c == 0 || c == 2 || c == 3 || c == 4, 1'b0, 1'b0);
            chk($sformatf("q_act_c%0d",  c), s_act,  q_act(c));
            chk($sformatf("q_pend_c%0d", c), s_pend, q_pend(c));
            chk($sformatf("q_ovf_c%0d",  c), s_ovf,  q_ovf(c));
        end

        // Request on the final guard cycle.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            tick(c == 0 || c == 7, 1'b0, 1'b0);
            chk($sformatf("lc_act_c%0d",  c), s_act,  lc_act(c));
            chk($sformatf("lc_pend_c%0d", c), s_pend, 0);
            chk($sformatf("lc_ovf_c%0d",  c), s_ovf,  lc_ovf(c));
        end

        // Overflow set and clear in the same cycle: set wins.
        do_reset();
        k = QD + 1;
        for (int c = 0; c <= k + 3; c++) begin
            tick(c <= k + 1, 1'b0, c == k + 1 || c == k + 2);
            if (c == k)     chk("sw_ovf_before", s_ovf, 0);
            if (c == k + 1) chk("sw_ovf_set",    s_ovf, 1);
            if (c == k + 2) chk("sw_ovf_wins",   s_ovf, 1);
            if (c == k + 3) chk("sw_ovf_clr",    s_ovf, 0);
        end

        // Abort during cooldown flushes the queue and ends in IDLE.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(c == 0 || c == 2, c == 6, 1'b0);
            if (c == 6) chk("ac_pend_c6", s_pend, (QD > 0) ? 1 : 0);
            if (c == 7) begin
                chk("ac_pend_c7", s_pend, 0);
                chk("ac_busy_c7", s_busy, 1);
            end
            if (c == 8) begin
                chk("ac_busy_c8", s_busy, 0);
                chk("ac_act_c8",  s_act,  0);
            end
            if (c == 9) chk("ac_done_c9", s_done, 0);
        end

        // Asynchronous reset mid-drive.
        do_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        #2;
        chk("ar_act_pre", int'(act_out), 1);
        reset = 1'b1;
        #1;
        chk("ar_act",  int'(act_out),  0);
        chk("ar_busy", int'(busy),     0);
        chk("ar_done", int'(done),     0);
        chk("ar_pend", int'(pending),  0);
        chk("ar_ovf",  int'(overflow), 0);
        do_reset();

        // Random requests and overflow clears against the schedule model.
        use_model = 1'b1;
        repeat (1500) tick($urandom_range(3) == 0, 1'b0, $urandom_range(15) == 0);
        use_model = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
